// File: rtl/fetch_seq_if.sv
// Fetch-to-execute bundle: ROM address/data, issued instruction fields and pipeline control.
// The master side (fetch_seq) drives pc and issue_*; the slave side supplies op, stall and cmp_flag.
interface fetch_seq_if;
    logic [7:0]  pc;
    logic [15:0] op;
    logic        stall;
    logic        cmp_flag;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [3:0]  issue_dst;
    logic [3:0]  issue_src1;
    logic [3:0]  issue_src0;
    logic [7:0]  issue_imm;
    logic        halted;

    modport master (
        output pc, issue_valid, issue_opcode, issue_dst, issue_src1, issue_src0, issue_imm,
               halted,
        input  op, stall, cmp_flag
    );

    modport slave (
        input  pc, issue_valid, issue_opcode, issue_dst, issue_src1, issue_src0, issue_imm,
               halted,
        output op, stall, cmp_flag
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch/sequencer: fetches from a combinational ROM and resolves branches locally.
// Non-branch ops go to execute; a branch behind COMP/CHECK waits one cycle; a self-jump halts.
module fetch_seq #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter logic [3:0] OP_JMP   = 4'hD,
    parameter logic [3:0] OP_JNZ   = 4'hE,
    parameter logic [3:0] OP_JNO   = 4'hF,
    parameter logic [3:0] OP_COMP  = 4'h1,
    parameter logic [3:0] OP_CHECK = 4'h2
) (
    input  logic        clk,
    input  logic        rst,
    fetch_seq_if.master bus
);
    typedef enum logic [1:0] {StRun, StFwait, StHalt} state_e;

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [7:0]  ir_pc_q;
    logic [15:0] ir_q;
    logic        ir_valid_q;
    logic        flag_pend_q;

    logic [3:0] ir_opc;
    logic       is_jmp, is_jnz, is_jno, is_cond, is_branch;
    logic       br_active, taken, self_jmp, issue_valid, flag_op;

    assign ir_opc    = ir_q[15:12];
    assign is_jmp    = (ir_opc == OP_JMP);
    assign is_jnz    = (ir_opc == OP_JNZ);
    assign is_jno    = (ir_opc == OP_JNO);
    assign is_cond   = is_jnz | is_jno;
    assign is_branch = is_jmp | is_cond;
    assign flag_op   = (ir_opc == OP_COMP) | (ir_opc == OP_CHECK);

    assign br_active   = ir_valid_q & is_branch;
    assign self_jmp    = is_jmp & (ir_q[7:0] == ir_pc_q);
    assign taken       = is_jmp | (is_jnz & bus.cmp_flag) | (is_jno & ~bus.cmp_flag);
    assign issue_valid = ir_valid_q & (state_q == StRun) & ~is_branch;

    assign bus.pc           = pc_q;
    assign bus.issue_valid  = issue_valid;
    assign bus.issue_opcode = ir_q[15:12];
    assign bus.issue_dst    = ir_q[11:8];
    assign bus.issue_src1   = ir_q[7:4];
    assign bus.issue_src0   = ir_q[3:0];
    assign bus.issue_imm    = ir_q[7:0];
    assign bus.halted       = (state_q == StHalt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            ir_pc_q     <= 8'd0;
            ir_q        <= 16'd0;
            ir_valid_q  <= 1'b0;
            flag_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    // Branches ignore stall: they never occupy execute.
                    if (br_active) begin
                        if (is_cond && flag_pend_q) begin
                            state_q <= StFwait;
                        end else if (self_jmp) begin
                            state_q    <= StHalt;
                            pc_q       <= ir_pc_q;
                            ir_valid_q <= 1'b0;
                        end else if (taken) begin
                            pc_q       <= ir_q[7:0];
                            ir_valid_q <= 1'b0;
                        end else begin
                            ir_q       <= bus.op;
                            ir_pc_q    <= pc_q;
                            ir_valid_q <= 1'b1;
                            pc_q       <= pc_q + 8'd1;
                        end
                    end else if (!bus.stall) begin
                        if (ir_valid_q) begin
                            flag_pend_q <= flag_op;
                        end
                        ir_q       <= bus.op;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_q + 8'd1;
                    end
                end
                StFwait: begin
                    state_q     <= StRun;
                    flag_pend_q <= 1'b0;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed scenarios plus random programs checked against an architectural (instruction-level)
// model of the sequencer: which ops must reach execute, in what order, and where it halts.
module tb_fetch_seq;
    logic        clk;
    logic        rst;
    logic [15:0] rom [256];
    int          checks;
    int          errors;

    logic [7:0]  mpc;
    int          accepts;

    fetch_seq_if bus ();

    fetch_seq #(.RESET_PC(8'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.op = rom[bus.pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] w);
        chk({tag, "_valid"}, 32'(bus.issue_valid), 32'd1);
        chk({tag, "_fields"},
            32'({bus.issue_opcode, bus.issue_dst, bus.issue_src1, bus.issue_src0}), 32'(w));
        chk({tag, "_imm"}, 32'(bus.issue_imm), 32'(w[7:0]));
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] exp_pc);
        chk({tag, "_pc"}, 32'(bus.pc), 32'(exp_pc));
        chk({tag, "_valid"}, 32'(bus.issue_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.cmp_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_filler();
        for (int a = 0; a < 256; a++) begin
            rom[a] = {4'($urandom_range(3, 12)), 12'($urandom)};
        end
    endtask

    // Forward-only branches guarantee the model never spins without issuing or halting.
    task automatic fill_random_rom();
        int r;
        int t;
        logic [3:0] opc;
        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 39);
            t = a + 1 + $urandom_range(0, 5);
            if (r == 0) begin
                rom[a] = {4'hD, 4'h0, 8'(a)};
            end else if (r < 10 && t < 256) begin
                opc = (r < 4) ? 4'hD : (r < 7) ? 4'hE : 4'hF;
                rom[a] = {opc, 4'($urandom), 8'(t)};
            end else if (r < 16) begin
                rom[a] = {(r < 13) ? 4'h1 : 4'h2, 12'($urandom)};
            end else begin
                rom[a] = {4'($urandom_range(3, 12)), 12'($urandom)};
            end
        end
    endtask

    // Next op that must reach execute, resolving branches with the current flag.
    task automatic model_next(output logic [15:0] eo, output bit eh);
        logic [15:0] w;
        bit          tk;
        eo = 16'd0;
        eh = 1'b0;
        for (int g = 0; g < 600; g++) begin
            w = rom[mpc];
            if (w[15:12] == 4'hD && w[7:0] == mpc) begin
                eh = 1'b1;
                return;
            end
            if (w[15:12] == 4'hD || w[15:12] == 4'hE || w[15:12] == 4'hF) begin
                tk = (w[15:12] == 4'hD) || (w[15:12] == 4'hE && bus.cmp_flag)
                     || (w[15:12] == 4'hF && !bus.cmp_flag);
                mpc = tk ? w[7:0] : mpc + 8'd1;
            end else begin
                eo  = w;
                mpc = mpc + 8'd1;
                return;
            end
        end
        eh = 1'b1;
    endtask

    initial begin
        logic [15:0] eo;
        bit          eh;
        bit          set_flag;
        bit          new_flag;
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Reset and straight-line issue.
        fill_filler();
        rom[0] = 16'h3A5C;
        rom[1] = 16'h4B21;
        rom[2] = 16'hC0FE;
        bus.stall    = 1'b0;
        bus.cmp_flag = 1'b0;
        @(negedge clk);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("line0_pc", 32'(bus.pc), 32'd1);
        chk_issue("line0", rom[0]);
        @(negedge clk);
        chk_issue("line1", rom[1]);
        @(negedge clk);
        chk("line2_pc", 32'(bus.pc), 32'd3);
        chk_issue("line2", rom[2]);

        // COMP then taken JNO: one FWAIT cycle, fall-through squashed.
        fill_filler();
        rom[0] = 16'h1123;
        rom[1] = 16'hF006;
        rom[2] = 16'h5555;
        rom[6] = 16'h6A6A;
        do_reset();
        @(negedge clk);
        chk_issue("jno_comp", rom[0]);
        @(negedge clk);
        chk_idle("jno_br", 8'd2);
        @(negedge clk);
        chk_idle("jno_fwait", 8'd2);
        @(negedge clk);
        chk_idle("jno_resolve", 8'd2);
        @(negedge clk);
        chk_idle("jno_bubble", 8'd6);
        @(negedge clk);
        chk("jno_tgt_pc", 32'(bus.pc), 32'd7);
        chk_issue("jno_tgt", rom[6]);

        // COMP then not-taken JNZ, then a 3-cycle stall on op@7.
        fill_filler();
        rom[4] = 16'h1456;
        rom[5] = 16'hE04D;
        rom[6] = 16'h7707;
        rom[7] = 16'h8808;
        rom[8] = 16'h9909;
        do_reset();
        for (int i = 1; i <= 5; i++) @(negedge clk);
        chk_issue("jnz_comp", rom[4]);
        @(negedge clk);
        chk_idle("jnz_br", 8'd6);
        @(negedge clk);
        chk_idle("jnz_fwait", 8'd6);
        @(negedge clk);
        chk_idle("jnz_resolve", 8'd6);
        @(negedge clk);
        chk("jnz_fall_pc", 32'(bus.pc), 32'd7);
        chk_issue("jnz_fall", rom[6]);
        @(negedge clk);
        chk_issue("stall_pre", rom[7]);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", 32'(bus.pc), 32'd8);
            chk_issue("stall_hold", rom[7]);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        chk("stall_post_pc", 32'(bus.pc), 32'd9);
        chk_issue("stall_post", rom[8]);

        // Self-jump at 78 halts; reset pulse recovers.
        fill_filler();
        rom[0]  = 16'hD04E;
        rom[78] = 16'hD04E;
        do_reset();
        for (int i = 0; i < 3; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_flag", 32'(bus.halted), 32'd1);
            chk_idle("halt", 8'd78);
        end
        rst = 1'b1;
        #1;
        chk("halt_rst_pc", 32'(bus.pc), 32'd0);
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        chk("halt_rst_valid", 32'(bus.issue_valid), 32'd0);

        // Random programs with random stall and random compare outcomes.
        for (int p = 0; p < 8; p++) begin
            fill_random_rom();
            do_reset();
            mpc     = 8'd0;
            accepts = 0;
            for (int c = 0; c < 1000 && accepts < 60; c++) begin
                @(negedge clk);
                if (bus.halted) break;
                bus.stall = ($urandom_range(0, 3) == 0);
                set_flag  = 1'b0;
                if (bus.issue_valid && !bus.stall) begin
                    accepts++;
                    model_next(eo, eh);
                    chk("rnd_unexpected_issue", 32'(eh), 32'd0);
                    chk("rnd_issue",
                        32'({bus.issue_opcode, bus.issue_dst, bus.issue_src1, bus.issue_src0}),
                        32'(eo));
                    if (eo[15:12] == 4'h1 || eo[15:12] == 4'h2) begin
                        set_flag = 1'b1;
                        new_flag = 1'($urandom);
                    end
                end
                @(posedge clk);
                #1;
                if (set_flag) bus.cmp_flag = new_flag;
            end
            if (bus.halted) begin
                model_next(eo, eh);
                chk("rnd_halt_expected", 32'(eh), 32'd1);
                chk("rnd_halt_pc", 32'(bus.pc), 32'(mpc));
                chk("rnd_halt_valid", 32'(bus.issue_valid), 32'd0);
            end else begin
                chk("rnd_progress", 32'(accepts >= 60), 32'd1);
            end
            bus.stall = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
